card_datapath: RTL
==================

Name: card_datapath

Overview:
- Baccarat hand datapath; sits directly downstream of the dealing state machine and consumes its six load strobes.
- Captures the dealt card rank into six card slots: player cards 1-3 and dealer cards 1-3.
- Feeds back to the state machine: pscore, dscore and pcard3 (the value of player card 3).
- Tracks which slots are filled, counts cards dealt, and flags protocol violations.

Parameters:
- RANK_W, 4, width of a card rank (1=Ace .. 13=King; 0 = empty slot).
- MAX_CARDS, 6, number of card slots; also the saturation limit of cards_dealt.

Ports:
- slow_clock  input  1  sole clock; all state updates on its rising edge.
- resetb  input  1  asynchronous, active-low reset.
- new_round  input  1  synchronous clear of all slots, the mask and the count; new_round does not clear protocol_err.
- new_card  input  4  rank offered for loading this cycle.
- load_pcard1, load_pcard2, load_pcard3  input  1 each  player slot load strobes.
- load_dcard1, load_dcard2, load_dcard3  input  1 each  dealer slot load strobes.
- pscore  output  4  player hand score, 0-9.
- dscore  output  4  dealer hand score, 0-9.
- pcard3  output  4  baccarat value (0-9) of player card 3; 0 when the slot is empty.
- loaded  output  6  slot-filled mask, bit order {d3,d2,d1,p3,p2,p1}.
- cards_dealt  output  3  number of slots filled, 0-6.
- protocol_err  output  1  sticky violation flag.
- hex_p1, hex_p2, hex_p3, hex_d1, hex_d2, hex_d3  output  7 each  active-low seven-segment rank display.

Behaviour:
- Reset (async, resetb=0):
  - all slot ranks = 0, loaded = 0, cards_dealt = 0, protocol_err = 0.
  - pscore, dscore and pcard3 therefore read 0.
  - all hex outputs = 7'h7F (blank).
- Card value mapping:
  - rank 1 -> 1; ranks 2-9 -> face value.
  - ranks 10-13 -> 0; rank 0 (empty) -> 0.
- Scores are combinational from the slot registers:
  - pscore = (v(p1)+v(p2)+v(p3)) mod 10; dscore likewise for the dealer slots.
  - Sum is 5 bits (max 27); mod 10 is done by conditional subtraction of 20 or 10. No divider.
  - A load at edge N is visible on the scores immediately after edge N, ready for the state machine's sample at edge N+1.
- A load is valid when all of the following hold:
  - exactly one strobe is high;
  - new_card is in 1..13;
  - the target slot's loaded bit is 0.
- On a valid load:
  - the slot takes new_card, its loaded bit is set, and cards_dealt increments.
- On an invalid load (any of the following):
  - two or more strobes high;
  - a strobe with new_card equal to 0, 14 or 15;
  - a strobe to an already-loaded slot.
  - Response: no slot changes, cards_dealt unchanged, protocol_err set to 1 on that edge.
- No strobes: all state is held.
- new_round=1:
  - clears slots, loaded and cards_dealt on that edge.
  - Has priority over any simultaneous strobe; the strobe is ignored and raises no error.
- protocol_err clears only on reset.
- cards_dealt never exceeds 6; this is guaranteed by the loaded-bit check.
- Reset asserted mid-hand clears everything asynchronously. The first valid load after reset release is accepted normally.

Optional Feature:
- Macro: CARD_HEX_EN.
- Defined: each hex_* output decodes its slot rank:
  - 1 -> "A", 2-9 -> digit glyph, 10 -> "0";
  - 11 -> "J", 12 -> "q", 13 -> "H";
  - empty slot -> blank (7'h7F).
  - The decode is registered, so hex_* updates one edge after the slot loads.
- Not defined: the hex_* ports still exist and are tied to 7'h7F. No decode logic is built.

Test Plan:
- Reset, then loads p1=9, d1=13, p2=5, d2=3 on successive edges -> pscore=4, dscore=3, loaded=6'b011011, cards_dealt=4, protocol_err=0.
- p1=10, p2=12, then p3=7 -> pcard3=7, pscore=7; a further load_pcard3 with new_card=2 -> slot unchanged, protocol_err=1, cards_dealt=3.
- load_pcard1 and load_dcard1 high together with new_card=4 -> no slot loaded, loaded=0, protocol_err=1.
- load_dcard2 with new_card=0, then with new_card=14 -> both rejected, dscore=0, protocol_err=1.
- Full hand loaded (cards_dealt=6), then new_round=1 together with load_pcard1 -> all slots empty, loaded=0, cards_dealt=0, scores=0; protocol_err keeps its prior value.
- CARD_HEX_EN defined: load p1=1, then d1=13 -> hex_p1 shows "A" one edge after its load and hex_d1 shows "H"; assert resetb=0 mid-hand -> all hex_* = 7'h7F immediately.

Source files
------------

// File: rtl/card_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | card_datapath : baccarat hand slots, scores, load checking, rank displays   |
// | Optional: CARD_HEX_EN builds the registered seven-segment rank decode.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module card_datapath #(
   parameter int RANK_W    = 4,
   parameter int MAX_CARDS = 6
) (
   input  logic              slow_clock,
   input  logic              resetb,
   input  logic              new_round,
   input  logic [RANK_W-1:0] new_card,
   input  logic              load_pcard1,
   input  logic              load_pcard2,
   input  logic              load_pcard3,
   input  logic              load_dcard1,
   input  logic              load_dcard2,
   input  logic              load_dcard3,
   output logic [3:0]        pscore,
   output logic [3:0]        dscore,
   output logic [3:0]        pcard3,
   output logic [5:0]        loaded,
   output logic [2:0]        cards_dealt,
   output logic              protocol_err,
   output logic [6:0]        hex_p1,
   output logic [6:0]        hex_p2,
   output logic [6:0]        hex_p3,
   output logic [6:0]        hex_d1,
   output logic [6:0]        hex_d2,
   output logic [6:0]        hex_d3
);

   // Slot index order matches the loaded mask: 0..2 = p1..p3, 3..5 = d1..d3
   logic [RANK_W-1:0]    rank_q [MAX_CARDS];
   logic [RANK_W-1:0]    rank_d [MAX_CARDS];
   logic [MAX_CARDS-1:0] loaded_q, loaded_d;
   logic [2:0]           cards_dealt_q, cards_dealt_d;
   logic                 protocol_err_q, protocol_err_d;

   logic [MAX_CARDS-1:0] w_strb;
   logic                 w_valid;

   function automatic logic [3:0] card_val(input logic [RANK_W-1:0] r);
      if (r >= RANK_W'(1) && r <= RANK_W'(9)) return 4'(r);
      return 4'd0;
   endfunction

   function automatic logic [3:0] mod10(input logic [4:0] s);
      if (s >= 5'd20) return 4'(s - 5'd20);
      if (s >= 5'd10) return 4'(s - 5'd10);
      return 4'(s);
   endfunction

   assign w_strb  = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};
   assign w_valid = $onehot(w_strb)
                 && (new_card >= RANK_W'(1)) && (new_card <= RANK_W'(13))
                 && ((w_strb & loaded_q) == '0);

   always_comb begin
      rank_d         = rank_q;
      loaded_d       = loaded_q;
      cards_dealt_d  = cards_dealt_q;
      protocol_err_d = protocol_err_q;
      if (new_round) begin
         for (int i = 0; i < MAX_CARDS; i++) rank_d[i] = '0;
         loaded_d      = '0;
         cards_dealt_d = 3'd0;
      end else if (|w_strb) begin
         if (w_valid) begin
            for (int i = 0; i < MAX_CARDS; i++)
               if (w_strb[i]) rank_d[i] = new_card;
            loaded_d      = loaded_q | w_strb;
            cards_dealt_d = cards_dealt_q + 3'd1;
         end else begin
            protocol_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < MAX_CARDS; i++) rank_q[i] <= '0;
         loaded_q       <= '0;
         cards_dealt_q  <= 3'd0;
         protocol_err_q <= 1'b0;
      end else begin
         rank_q         <= rank_d;
         loaded_q       <= loaded_d;
         cards_dealt_q  <= cards_dealt_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign pscore       = mod10(5'(card_val(rank_q[0])) + 5'(card_val(rank_q[1]))
                             + 5'(card_val(rank_q[2])));
   assign dscore       = mod10(5'(card_val(rank_q[3])) + 5'(card_val(rank_q[4]))
                             + 5'(card_val(rank_q[5])));
   assign pcard3       = card_val(rank_q[2]);
   assign loaded       = loaded_q;
   assign cards_dealt  = cards_dealt_q;
   assign protocol_err = protocol_err_q;

`ifdef CARD_HEX_EN
   logic [6:0] hex_q [MAX_CARDS];
   logic [6:0] hex_d [MAX_CARDS];

   // Active-low segments, bit order gfedcba
   function automatic logic [6:0] seg_decode(input logic [RANK_W-1:0] r);
      case (r)
         RANK_W'(1):  return 7'h08;
         RANK_W'(2):  return 7'h24;
         RANK_W'(3):  return 7'h30;
         RANK_W'(4):  return 7'h19;
         RANK_W'(5):  return 7'h12;
         RANK_W'(6):  return 7'h02;
         RANK_W'(7):  return 7'h78;
         RANK_W'(8):  return 7'h00;
         RANK_W'(9):  return 7'h10;
         RANK_W'(10): return 7'h40;
         RANK_W'(11): return 7'h61;
         RANK_W'(12): return 7'h18;
         RANK_W'(13): return 7'h09;
         default:     return 7'h7F;
      endcase
   endfunction

   for (genvar g = 0; g < MAX_CARDS; g++) begin : g_hex
      always_comb hex_d[g] = seg_decode(rank_q[g]);

      always_ff @(posedge slow_clock or negedge resetb) begin
         if (!resetb) hex_q[g] <= 7'h7F;
         else         hex_q[g] <= hex_d[g];
      end
   end

   assign hex_p1 = hex_q[0];
   assign hex_p2 = hex_q[1];
   assign hex_p3 = hex_q[2];
   assign hex_d1 = hex_q[3];
   assign hex_d2 = hex_q[4];
   assign hex_d3 = hex_q[5];
`else
   assign hex_p1 = 7'h7F;
   assign hex_p2 = 7'h7F;
   assign hex_p3 = 7'h7F;
   assign hex_d1 = 7'h7F;
   assign hex_d2 = 7'h7F;
   assign hex_d3 = 7'h7F;
`endif

endmodule
`default_nettype wire
